// File: rtl/lcd_page_buffer.sv
// Fetches one 8x8-block image page from ROM, transposes it into 64 LCD column
// bytes, then streams the columns to the LCD controller one data_next at a time.
module lcd_page_buffer (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_request,
  input  logic [6:0]  addr,
  input  logic        data_next,
  output logic        data_ack,
  output logic [7:0]  data,
  output logic        busy,
  output logic [12:0] rom_addr,
  input  logic [7:0]  rom_data
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ACK, S_STREAM} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [6:0]  r_page;
  logic [6:0]  r_fetch_cnt;
  logic [5:0]  r_rd_ptr;
  logic [12:0] r_rom_addr;

  logic [5:0]  w_cap_idx;
  logic        w_cap_en;
  logic [7:0]  w_bank_rd [0:7];

  // ROM data lags the address by one cycle, so fetch count n captures byte n-1.
  assign w_cap_idx = r_fetch_cnt[5:0] - 6'd1;
  assign w_cap_en  = (r_state == S_FETCH) && (r_fetch_cnt != 7'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (data_request) w_state_next = S_FETCH;
      S_FETCH:  if (r_fetch_cnt == 7'd64) w_state_next = S_ACK;
      S_ACK:    w_state_next = S_STREAM;
      S_STREAM: if (data_next && (r_rd_ptr == 6'd63)) w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_page      <= 7'd0;
      r_fetch_cnt <= 7'd0;
      r_rd_ptr    <= 6'd0;
      r_rom_addr  <= 13'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (data_request) begin
            r_page      <= addr;
            r_rom_addr  <= {addr, 6'd0};
            r_fetch_cnt <= 7'd0;
          end
        end
        S_FETCH: begin
          r_fetch_cnt <= r_fetch_cnt + 7'd1;
          if (r_fetch_cnt < 7'd63) begin
            r_rom_addr <= {r_page, r_fetch_cnt[5:0] + 6'd1};
          end
        end
        S_ACK: begin
          r_rd_ptr <= 6'd0;
        end
        S_STREAM: begin
          if (data_next) r_rd_ptr <= r_rd_ptr + 6'd1;
        end
        default: ;
      endcase
    end
  end

  // Bank gi holds column 8*blk+gi, indexed by blk; bit row comes from ROM bit 7-gi.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_bank
      logic [7:0] r_bank [0:7];

      always_ff @(posedge clk) begin
        if (w_cap_en) begin
          r_bank[w_cap_idx[2:0]][w_cap_idx[5:3]] <= rom_data[7-gi];
        end
      end

      assign w_bank_rd[gi] = r_bank[r_rd_ptr[5:3]];
    end
  endgenerate

  always_comb begin
    busy     = (r_state != S_IDLE);
    data_ack = (r_state == S_ACK);
    data     = 8'h00;
    if ((r_state == S_ACK) || (r_state == S_STREAM)) begin
      data = w_bank_rd[r_rd_ptr[2:0]];
    end
  end

  assign rom_addr = r_rom_addr;

endmodule

// File: tb/tb_lcd_page_buffer.sv
// Scoreboard bench for lcd_page_buffer: stimulus queues expected columns and ack
// times, a negedge monitor pops and compares as the DUT acks and streams bytes.
module tb_lcd_page_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_request;
  logic [6:0]  addr;
  logic        data_next;
  logic        data_ack;
  logic [7:0]  data;
  logic        busy;
  logic [12:0] rom_addr;
  logic [7:0]  rom_data = 8'h00;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rom_mode = 0;
  int acks_seen = 0;

  logic [7:0] exp_col_q [$];
  int         exp_ack_q [$];
  logic       in_stream = 1'b0;
  logic       prev_ack  = 1'b0;
  int         taken     = 0;

  lcd_page_buffer dut (
    .clk          (clk),
    .rst          (rst),
    .data_request (data_request),
    .addr         (addr),
    .data_next    (data_next),
    .data_ack     (data_ack),
    .data         (data),
    .busy         (busy),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // mode 0: low address byte; mode 1: 0x80 in blk 0; mode 2: diagonal in blk 3
  function automatic logic [7:0] rom_fn(input int m, input logic [12:0] a);
    logic [2:0] row;
    logic [2:0] blk;
    row = a[5:3];
    blk = a[2:0];
    case (m)
      0:       return a[7:0];
      1:       return (blk == 3'd0) ? 8'h80 : 8'h00;
      2:       return (blk == 3'd3) ? (8'h80 >> row) : 8'h00;
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk) rom_data <= rom_fn(rom_mode, rom_addr);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, want, cyc);
    end
  endtask

  // Monitor: ack latency/uniqueness, then one column compare per data_next.
  always @(negedge clk) begin
    if (data_ack) begin
      acks_seen++;
      if (prev_ack) chk("ack_single", 32'd1, 32'd0);
      if (exp_ack_q.size() == 0) begin
        chk("ack_unexpected", 32'd1, 32'd0);
      end else begin
        chk("ack_latency", cyc, exp_ack_q.pop_front());
        if (exp_col_q.size() > 0) chk("ack_data", {24'd0, data}, {24'd0, exp_col_q[0]});
        $display("page ack at cyc %0d", cyc);
      end
      in_stream = 1'b1;
      taken = 0;
    end else if (in_stream && data_next) begin
      if (exp_col_q.size() == 0) chk("col_extra", 32'd1, 32'd0);
      else chk($sformatf("col%0d", taken), {24'd0, data}, {24'd0, exp_col_q.pop_front()});
      taken++;
      if (taken == 64) in_stream = 1'b0;
    end
    prev_ack = data_ack;
  end

  // Caller sits just after a posedge with the DUT in IDLE.
  task automatic run_page(input logic [6:0] a, input int mode, input bit chg,
                          input int hold, input bit chain);
    logic [7:0] col;
    logic [5:0] ii;
    int tc, w, sent, j;
    rom_mode = mode;
    for (int c = 0; c < 64; c++) begin
      col = 8'h00;
      case (mode)
        0: for (int r = 0; r < 8; r++) begin
             logic [7:0] b;
             b = {a[1:0], 3'(r), 3'(c / 8)};
             col[r] = b[7 - (c % 8)];
           end
        1: col = (c == 0) ? 8'hFF : 8'h00;
        2: col = (c >= 24 && c < 32) ? (8'h01 << (c - 24)) : 8'h00;
        default: col = 8'h00;
      endcase
      exp_col_q.push_back(col);
    end
    addr = a;
    data_request = 1'b1;
    @(posedge clk); #1;
    tc = cyc;
    exp_ack_q.push_back(tc + 65);
    for (int i = 0; i <= 64; i++) begin
      @(negedge clk);
      ii = (i > 63) ? 6'd63 : 6'(i);
      chk("rom_addr", {19'd0, rom_addr}, {19'd0, a, ii});
      if (i == 0 || i == 64) begin
        chk("fetch_data", {24'd0, data}, 32'd0);
        chk("fetch_busy", {31'd0, busy}, 32'd1);
      end
      if (chg && i == 10) addr = a + 7'd1;
    end
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!data_ack && w < 5);
    if (!data_ack) chk("ack_timeout", 32'd0, 32'd1);
    sent = 0;
    j = 0;
    while (sent < 64) begin
      @(posedge clk); #1;
      if (j == hold) data_request = 1'b0;
      if (j % 4 == 3) begin
        data_next = 1'b0;
      end else begin
        data_next = 1'b1;
        sent++;
        if (sent == 64 && chain) data_request = 1'b1;
      end
      j++;
    end
    @(posedge clk); #1;
    data_next = 1'b0;
    @(negedge clk);
    chk("busy_after_stream", {31'd0, busy}, 32'd0);
    if (chain) begin
      @(negedge clk);
      chk("req_from_idle", {31'd0, busy}, 32'd1);
      data_request = 1'b0;
    end else begin
      @(posedge clk); #1 data_next = 1'b1;
      @(posedge clk); #1 data_next = 1'b0;
      @(negedge clk);
      chk("idle_next_busy", {31'd0, busy}, 32'd0);
      chk("idle_next_data", {24'd0, data}, 32'd0);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int a0;
    rst = 1'b1;
    data_request = 1'b1;
    addr = 7'h05;
    data_next = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ack", {31'd0, data_ack}, 32'd0);
    chk("rst_data", {24'd0, data}, 32'd0);
    chk("rst_rom_addr", {19'd0, rom_addr}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_page(7'h05, 0, 1'b0, 0, 1'b0);
    run_page(7'h00, 1, 1'b0, 2, 1'b0);
    run_page(7'h2A, 2, 1'b0, 0, 1'b0);
    run_page(7'h10, 0, 1'b1, 0, 1'b0);

    // reset in FETCH cycle 30 aborts with no ack
    addr = 7'h05;
    data_request = 1'b1;
    @(posedge clk); #1;
    data_request = 1'b0;
    repeat (30) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_rom_addr", {19'd0, rom_addr}, 32'd0);
    chk("abort_data", {24'd0, data}, 32'd0);
    a0 = acks_seen;
    repeat (70) @(negedge clk);
    chk("abort_no_ack", acks_seen - a0, 32'd0);
    @(posedge clk); #1;
    run_page(7'h33, 0, 1'b0, 0, 1'b1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    a0 = acks_seen;
    repeat (70) @(negedge clk);
    chk("chain_abort_no_ack", acks_seen - a0, 32'd0);
    chk("ack_q_empty", exp_ack_q.size(), 32'd0);
    chk("col_q_empty", exp_col_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
